// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: shift funct codes, shifter op encoding, widths and the issue payload.
package cpu_defs;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned REG_W   = 5;
  localparam int unsigned FUNCT_W = 6;

  localparam logic [FUNCT_W-1:0] FUNCT_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] FUNCT_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] FUNCT_SRA  = 6'b000011;
  localparam logic [FUNCT_W-1:0] FUNCT_SLLV = 6'b000100;
  localparam logic [FUNCT_W-1:0] FUNCT_SRLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] FUNCT_SRAV = 6'b000111;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_RSV = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  typedef struct packed {
    logic [DATA_W-1:0]  data_a;
    logic [SHAMT_W-1:0] shamt;
    shift_op_e          op;
    logic [REG_W-1:0]   rd;
    logic               wb_en;
    logic               illegal;
  } issue_pkt_t;

endpackage

// File: rtl/shift_decode.sv
// Combinational R-type shift decode: op, shift-amount source, write-back enable, illegal flag.
module shift_decode
  import cpu_defs::*;
(
  input  logic [FUNCT_W-1:0] funct,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [SHAMT_W-1:0] rs_lo,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic [REG_W-1:0]   rd,
  output issue_pkt_t         pkt_c
);

  always_comb begin
    pkt_c         = '0;
    pkt_c.data_a  = rt_data;
    pkt_c.rd      = rd;
    pkt_c.op      = OP_RSV;
    pkt_c.illegal = 1'b1;
    case (funct)
      FUNCT_SLL:  begin pkt_c.op = OP_SLL; pkt_c.shamt = shamt; pkt_c.illegal = 1'b0; end
      FUNCT_SRL:  begin pkt_c.op = OP_SRL; pkt_c.shamt = shamt; pkt_c.illegal = 1'b0; end
      FUNCT_SRA:  begin pkt_c.op = OP_SRA; pkt_c.shamt = shamt; pkt_c.illegal = 1'b0; end
      FUNCT_SLLV: begin pkt_c.op = OP_SLL; pkt_c.shamt = rs_lo; pkt_c.illegal = 1'b0; end
      FUNCT_SRLV: begin pkt_c.op = OP_SRL; pkt_c.shamt = rs_lo; pkt_c.illegal = 1'b0; end
      FUNCT_SRAV: begin pkt_c.op = OP_SRA; pkt_c.shamt = rs_lo; pkt_c.illegal = 1'b0; end
      default:    ;
    endcase
    pkt_c.wb_en = !pkt_c.illegal && (rd != '0);
  end

endmodule

// File: rtl/shift_issue_stage.sv
// ID->EX issue stage for shifts with a 2-entry skid buffer and registered ready.
// Optional perf counters (perf_issued, perf_stall) enabled by defining SHIFT_ISSUE_PERF_EN.
module shift_issue_stage
  import cpu_defs::*;
#(
  parameter int unsigned DATA_W_P  = DATA_W,
  parameter int unsigned SHAMT_W_P = SHAMT_W,
  parameter int unsigned REG_W_P   = REG_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [5:0]           in_funct,
  input  logic [SHAMT_W_P-1:0] in_shamt,
  input  logic [DATA_W_P-1:0]  in_rs_data,
  input  logic [DATA_W_P-1:0]  in_rt_data,
  input  logic [REG_W_P-1:0]   in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W_P-1:0]  out_data_a,
  output logic [SHAMT_W_P-1:0] out_shamt,
  output logic [1:0]           out_op,
  output logic [REG_W_P-1:0]   out_rd,
  output logic                 out_wb_en,
  output logic                 out_illegal
`ifdef SHIFT_ISSUE_PERF_EN
  ,
  output logic [31:0]          perf_issued,
  output logic [31:0]          perf_stall
`endif
);

  buf_state_e state_q, state_d;
  issue_pkt_t main_q, skid_q, dec_pkt;
  logic       in_ready_q, out_valid_q;
  logic       accept, pop;
  logic       load_main, main_from_skid, load_skid;
  logic       unused_rs_hi;

  // Only rs[4:0] can ever be a shift amount.
  assign unused_rs_hi = ^in_rs_data[DATA_W_P-1:SHAMT_W_P];

  shift_decode u_decode (
    .funct   (in_funct),
    .shamt   (in_shamt),
    .rs_lo   (in_rs_data[SHAMT_W_P-1:0]),
    .rt_data (in_rt_data),
    .rd      (in_rd),
    .pkt_c   (dec_pkt)
  );

  assign accept = in_valid & in_ready_q;
  assign pop    = out_valid_q & out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d != ST_TWO);
      out_valid_q <= (state_d != ST_EMPTY);
    end
  end

  // Next state and buffer moves; flush wins over any same-cycle accept or pop.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) begin
          load_main = 1'b1;
          state_d   = ST_ONE;
        end
        ST_ONE: begin
          if (accept && pop) begin
            load_main = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = ST_TWO;
          end else if (pop) begin
            state_d = ST_EMPTY;
          end
        end
        ST_TWO: if (pop) begin
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main)           main_q <= dec_pkt;
      else if (main_from_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= dec_pkt;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data_a  = main_q.data_a;
  assign out_shamt   = main_q.shamt;
  assign out_op      = main_q.op;
  assign out_rd      = main_q.rd;
  assign out_wb_en   = main_q.wb_en;
  assign out_illegal = main_q.illegal;

`ifdef SHIFT_ISSUE_PERF_EN
  // Free-running wrap-around counters; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (pop)                     perf_issued <= perf_issued + 32'd1;
      if (in_valid && !in_ready_q) perf_stall  <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_shift_issue_stage.sv
// Directed self-checking bench for shift_issue_stage (perf checks under SHIFT_ISSUE_PERF_EN).
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_funct;
  logic [4:0]  in_shamt;
  logic [31:0] in_rs_data;
  logic [31:0] in_rt_data;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data_a;
  logic [4:0]  out_shamt;
  logic [1:0]  out_op;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;
`ifdef SHIFT_ISSUE_PERF_EN
  logic [31:0] perf_issued;
  logic [31:0] perf_stall;
`endif

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  shift_issue_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_funct    (in_funct),
    .in_shamt    (in_shamt),
    .in_rs_data  (in_rs_data),
    .in_rt_data  (in_rt_data),
    .in_rd       (in_rd),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data_a  (out_data_a),
    .out_shamt   (out_shamt),
    .out_op      (out_op),
    .out_rd      (out_rd),
    .out_wb_en   (out_wb_en),
    .out_illegal (out_illegal)
`ifdef SHIFT_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_stall  (perf_stall)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                       input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] rd);
    in_valid   = v;
    in_funct   = f;
    in_shamt   = sh;
    in_rs_data = rs;
    in_rt_data = rt;
    in_rd      = rd;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    repeat (2) step();
    check_idle("rst");
    check("rst_data", out_data_a, 32'd0);
    check("rst_misc", {out_shamt, out_op, out_rd, out_wb_en, out_illegal}, 32'd0);
    rst_n = 1'b1;
    step();

    // SLL immediate
    out_ready = 1'b1;
    drive(1'b1, 6'b000000, 5'd4, 32'hDEAD_BEEF, 32'h0000_00F1, 5'd3);
    step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("sll_valid", 32'(out_valid), 32'd1);
    check("sll_data", out_data_a, 32'h0000_00F1);
    check("sll_shamt", 32'(out_shamt), 32'd4);
    check("sll_op", 32'(out_op), 32'd0);
    check("sll_rd", 32'(out_rd), 32'd3);
    check("sll_wb", 32'(out_wb_en), 32'd1);
    check("sll_ill", 32'(out_illegal), 32'd0);
    step();
    check("sll_drain", 32'(out_valid), 32'd0);

    // SRAV: shamt from rs[4:0], rd=0 disables write-back
    drive(1'b1, 6'b000111, 5'd17, 32'hFFFF_FFE5, 32'h8000_0000, 5'd0);
    step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("srav_data", out_data_a, 32'h8000_0000);
    check("srav_shamt", 32'(out_shamt), 32'd5);
    check("srav_op", 32'(out_op), 32'd2);
    check("srav_wb", 32'(out_wb_en), 32'd0);
    step();

    // SRLV with rd!=0
    drive(1'b1, 6'b000110, 5'd0, 32'h0000_001F, 32'h1234_5678, 5'd9);
    step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("srlv_shamt", 32'(out_shamt), 32'd31);
    check("srlv_op", 32'(out_op), 32'd1);
    check("srlv_wb", 32'(out_wb_en), 32'd1);
    step();

    // Illegal funct
    drive(1'b1, 6'b100000, 5'd9, 32'h0000_0003, 32'h0000_0055, 5'd5);
    step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("ill_flag", 32'(out_illegal), 32'd1);
    check("ill_op", 32'(out_op), 32'd3);
    check("ill_wb", 32'(out_wb_en), 32'd0);
    check("ill_shamt", 32'(out_shamt), 32'd0);
    step();

    // Back-pressure: A, B fill the buffer, C is refused until a slot frees
    out_ready = 1'b0;
    drive(1'b1, 6'b000010, 5'd1, 32'd0, 32'hAAAA_0001, 5'd1);
    step();
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_ready", 32'(in_ready), 32'd1);
    drive(1'b1, 6'b000010, 5'd2, 32'd0, 32'hBBBB_0002, 5'd2);
    step();
    check("bp_b_ready", 32'(in_ready), 32'd0);
    check("bp_b_hold", out_data_a, 32'hAAAA_0001);
    drive(1'b1, 6'b000010, 5'd3, 32'd0, 32'hCCCC_0003, 5'd3);
    step();
    check("bp_c_hold", out_data_a, 32'hAAAA_0001);
    check("bp_c_shamt", 32'(out_shamt), 32'd1);
    check("bp_c_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    step();
    check("bp_out_b", out_data_a, 32'hBBBB_0002);
    check("bp_b_rd", 32'(out_rd), 32'd2);
    check("bp_ready_back", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("bp_out_c", out_data_a, 32'hCCCC_0003);
    check("bp_c_valid", 32'(out_valid), 32'd1);
    step();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Flush in TWO with an incoming instruction
    out_ready = 1'b0;
    drive(1'b1, 6'b000000, 5'd1, 32'd0, 32'h0000_0011, 5'd1);
    step();
    drive(1'b1, 6'b000000, 5'd2, 32'd0, 32'h0000_0022, 5'd2);
    step();
    check("fl_two", 32'(in_ready), 32'd0);
    flush = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 6'b000000, 5'd3, 32'd0, 32'h0000_0033, 5'd3);
    step();
    flush = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check_idle("fl_after");
    step();
    check("fl_dropped", 32'(out_valid), 32'd0);

    // Flush while in ONE discards a same-cycle accept
    drive(1'b1, 6'b000011, 5'd7, 32'd0, 32'h0000_0044, 5'd4);
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("fl1_valid", 32'(out_valid), 32'd0);
    step();
    check("fl1_dropped", 32'(out_valid), 32'd0);

    // Async reset mid-operation with both entries full
    out_ready = 1'b0;
    drive(1'b1, 6'b000000, 5'd6, 32'd0, 32'h0000_0066, 5'd6);
    step();
    drive(1'b1, 6'b000000, 5'd7, 32'd0, 32'h0000_0077, 5'd7);
    step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("mr_two", 32'(in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_idle("mr");
    check("mr_data", out_data_a, 32'd0);
    check("mr_misc", {out_shamt, out_op, out_rd, out_wb_en, out_illegal}, 32'd0);
    step();
    rst_n = 1'b1;
    step();
    check("mr_stays_empty", 32'(out_valid), 32'd0);

`ifdef SHIFT_ISSUE_PERF_EN
    check("perf_rst_iss", perf_issued, 32'd0);
    check("perf_rst_stall", perf_stall, 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 6'b000100, 5'd0, 32'(i), 32'(i + 100), 5'd1);
      step();
    end
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    check("perf_last", out_data_a, 32'd107);
    step();
    check("perf_iss8", perf_issued, 32'd8);
    out_ready = 1'b0;
    drive(1'b1, 6'b000000, 5'd1, 32'd0, 32'd1, 5'd1);
    repeat (5) step();
    drive(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 5'd0);
    out_ready = 1'b1;
    repeat (2) step();
    check("perf_issued", perf_issued, 32'd10);
    check("perf_stall", perf_stall, 32'd3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("perf_flush_keep", perf_issued, 32'd10);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
